// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared definitions for the ALU sequencing front end.
//   - ALU opcode encodings (OPC_LOAD is handled locally and never reaches the ALU)
//   - controller state encoding
//   - small opcode helper
package alu_ctrl_pkg;

    localparam logic [2:0] OPC_NEG    = 3'b000;
    localparam logic [2:0] OPC_INC    = 3'b001;
    localparam logic [2:0] OPC_ADD    = 3'b010;
    localparam logic [2:0] OPC_ADDSHR = 3'b011;
    localparam logic [2:0] OPC_AND    = 3'b100;
    localparam logic [2:0] OPC_OR     = 3'b101;
    localparam logic [2:0] OPC_CAT    = 3'b110;
    localparam logic [2:0] OPC_LOAD   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    function automatic logic is_load(input logic [2:0] opc);
        return opc == OPC_LOAD;
    endfunction

endpackage

// File: rtl/alu_ctrl_regfile.sv
// alu_ctrl_regfile: NREG x W register file for the ALU controller.
// Ports:
//   clk, rst              clock, synchronous active-high clear of every entry
//   we, waddr, wdata      synchronous write port
//   raddr_a/rdata_a       combinational read port A
//   raddr_b/rdata_b       combinational read port B
// Reads return the stored value, so a read and write of the same entry in one
// cycle sees the old value.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned W    = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] waddr,
    input  logic [W-1:0]            wdata,
    input  logic [$clog2(NREG)-1:0] raddr_a,
    output logic [W-1:0]            rdata_a,
    input  logic [$clog2(NREG)-1:0] raddr_b,
    output logic [W-1:0]            rdata_b
);

    logic [W-1:0] mem [NREG];

    // Reset has priority so an operation aborted by reset leaves no write behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_ctrl.sv
// alu_ctrl: sequencing front end for the 16-bit combinational ALU.
// Accepts one command at a time, drives the ALU operands for a single EXEC
// cycle, writes the result back into a 4-entry register file and presents it
// on a valid/ready result interface.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cmd_valid/cmd_ready           command handshake
//   cmd_opc/dst/srca/srcb/useimm/inc/imm   command payload (opc 3'b111 = LOAD)
//   alu_opc/ina/inb/inc           ALU operands, nonzero only in EXEC
//   alu_w/zer/neg                 ALU result and flags
//   res_valid/res_ready           result handshake
//   res_data/zer/neg/dst          result payload
//   perf_ops                      completed-command counter, only with
//                                 ALU_CTRL_PERF_EN defined
// Configuration macro: ALU_CTRL_PERF_EN
module alu_ctrl
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 4,
    parameter int unsigned W    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_opc,
    input  logic [1:0]   cmd_dst,
    input  logic [1:0]   cmd_srca,
    input  logic [1:0]   cmd_srcb,
    input  logic         cmd_useimm,
    input  logic         cmd_inc,
    input  logic [W-1:0] cmd_imm,
    output logic [2:0]   alu_opc,
    output logic [W-1:0] alu_ina,
    output logic [W-1:0] alu_inb,
    output logic         alu_inc,
    input  logic [W-1:0] alu_w,
    input  logic         alu_zer,
    input  logic         alu_neg,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_zer,
    output logic         res_neg,
    output logic [1:0]   res_dst
`ifdef ALU_CTRL_PERF_EN
    ,
    output logic [15:0]  perf_ops
`endif
);

    state_e       state_q;
    logic         load_q;
    logic [1:0]   dst_q;
    logic [W-1:0] imm_q;

    logic [W-1:0] rd_a;
    logic [W-1:0] rd_b;
    logic         rf_we;
    logic [W-1:0] rf_wdata;
    logic         res_done;

    // Gated by rst so a handshake never lands in the reset cycle.
    assign cmd_ready = (state_q == IDLE) && !rst;

    // Read ports are addressed straight from the command inputs; the values
    // are captured into the ALU operand registers on the handshake edge.
    assign rf_we    = (state_q == EXEC);
    assign rf_wdata = load_q ? imm_q : alu_w;
    assign res_done = (state_q == RESP) && res_valid && res_ready;

    alu_ctrl_regfile #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (dst_q),
        .wdata   (rf_wdata),
        .raddr_a (cmd_srca),
        .rdata_a (rd_a),
        .raddr_b (cmd_srcb),
        .rdata_b (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            load_q    <= 1'b0;
            dst_q     <= '0;
            imm_q     <= '0;
            alu_opc   <= '0;
            alu_ina   <= '0;
            alu_inb   <= '0;
            alu_inc   <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_zer   <= 1'b0;
            res_neg   <= 1'b0;
            res_dst   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        load_q <= is_load(cmd_opc);
                        dst_q  <= cmd_dst;
                        imm_q  <= cmd_imm;
                        // LOAD keeps the ALU port quiet for the whole operation.
                        if (is_load(cmd_opc)) begin
                            alu_opc <= '0;
                            alu_ina <= '0;
                            alu_inb <= '0;
                            alu_inc <= 1'b0;
                        end else begin
                            alu_opc <= cmd_opc;
                            alu_ina <= rd_a;
                            alu_inb <= cmd_useimm ? cmd_imm : rd_b;
                            alu_inc <= cmd_inc;
                        end
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    alu_opc <= '0;
                    alu_ina <= '0;
                    alu_inb <= '0;
                    alu_inc <= 1'b0;
                    res_dst <= dst_q;
                    if (load_q) begin
                        res_data <= imm_q;
                        res_zer  <= (imm_q == '0);
                        res_neg  <= imm_q[W-1];
                    end else begin
                        res_data <= alu_w;
                        res_zer  <= alu_zer;
                        res_neg  <= alu_neg;
                    end
                    state_q <= RESP;
                end
                RESP: begin
                    // First RESP cycle raises res_valid; payload is already stable.
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops <= '0;
        end else if (res_done) begin
            perf_ops <= perf_ops + 16'd1;
        end
    end
`else
    // res_done only feeds the optional counter.
    logic unused_res_done;
    assign unused_res_done = res_done;
`endif

endmodule
